recompute_scheduler: RTL and testbench
======================================

# recompute_scheduler

Sequencer that time-shares the single recompute unit among all PEs flagged faulty by BIST/diagnosis in the ROWSxCOLS systolic array. It holds a small fault table of one-hot (row, col) entries. On each start it issues one entry per cycle to the recompute unit, together with that PE's weight and its row's left input. It reports completion after the recompute pipeline drains.

## Interface
- ROWS, 3, systolic array rows
- COLS, 3, systolic array columns
- WORD_SIZE, 16, data word width
- MAX_FAULTS, 4, fault table depth (≥1)
- RU_LATENCY, 1, cycles from recompute-unit input to BottomOut valid (≥1)

- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- fault_wr_en  in  1  write one fault entry (IDLE only)
- fault_row_in  in  ROWS  one-hot faulty row
- fault_col_in  in  COLS  one-hot faulty column
- fault_clear  in  1  empty the table (IDLE only)
- start  in  1  begin a recompute pass
- hold  in  1  stall issue
- weights_in  in  ROWS*COLS*WORD_SIZE  PE weights; PE (r,c) at slice index r*COLS+c
- left_in  in  ROWS*WORD_SIZE  per-row left inputs; row r at slice r
- faultyRowOut  out  ROWS  one-hot row to recompute unit
- faultyColOut  out  COLS  one-hot column to recompute unit
- Weight  out  WORD_SIZE  selected weight
- LeftIn  out  WORD_SIZE  selected left input
- ru_valid  out  1  issue outputs valid this cycle
- busy  out  1  pass in progress
- done  out  1  one-cycle end-of-pass pulse
- fault_count  out  $clog2(MAX_FAULTS+1)  valid entries
- table_full  out  1  fault_count == MAX_FAULTS
- fault_err  out  1  sticky; rejected write (full, non-one-hot, or during busy)

## Operation
- States: IDLE, ISSUE, DRAIN, DONE.
- Reset: state=IDLE, table empty, all outputs 0 (faultyRowOut/faultyColOut/Weight/LeftIn=0, ru_valid=busy=done=fault_err=0, fault_count=0).
- Table write, IDLE only, when fault_wr_en=1. The entry is appended at index fault_count.
  - Rejected, setting fault_err: table full; fault_row_in or fault_col_in not exactly one-hot; write while not IDLE.
  - Duplicate of an existing entry: silently ignored, no error, count unchanged.
- fault_clear in IDLE: count→0. fault_err→0. Clear beats a same-cycle write. Clear outside IDLE is ignored.
- IDLE + start: →ISSUE with idx=0, busy=1. With fault_count=0, go →DONE instead. start while not IDLE is ignored.
- ISSUE, hold=0: register entry idx onto faultyRowOut/faultyColOut.
  - Weight = weights_in slice (r*COLS+c) for one-hot position (r,c). LeftIn = left_in slice r.
  - Both sampled at that same edge. ru_valid=1. idx++.
  - After idx = fault_count−1 is issued: →DRAIN with drain counter = RU_LATENCY.
- ISSUE, hold=1: ru_valid=0, idx frozen; data outputs keep their last values.
- DRAIN: ru_valid=0, hold is ignored. Counter decrements each cycle; at 0 →DONE.
- DONE: done=1 and busy=0 for one cycle, then →IDLE. Data outputs hold their last values.
- Table contents persist across passes until cleared or reset.
- Asserting rst mid-pass: immediate return to IDLE. Table is emptied. No done pulse.

## Timing
- All outputs are registered; there are no combinational input→output paths.
- start sampled at edge t0 → busy=1 from t0.
- Entry i is driven with ru_valid=1 after edge t0+1+i, assuming no hold. Each cycle of hold adds one cycle.
- Last issue at edge t0+N. DRAIN spans RU_LATENCY cycles. done=1 after edge t0+N+RU_LATENCY+1, for exactly one cycle.
- N=0: done=1 after edge t0+1, with no ru_valid.
- fault_count and table_full update the edge after an accepted write or clear.
- Back-to-back: start in the DONE cycle is ignored. It is accepted from IDLE, one cycle after done.

## Test plan
- Reset then idle: after rst high, all outputs 0. start with an empty table → done after 1 cycle, ru_valid never 1.
- Two-fault pass, RU_LATENCY=1:
  - Stimulus: write (row=001,col=010) and (row=100,col=001). weights_in has PE(0,1)=3 and PE(2,0)=7. left_in has row0=4 and row2=8. Then start.
  - Response: cycle 1 drives row 001, col 010, Weight 3, LeftIn 4. Cycle 2 drives row 100, col 001, Weight 7, LeftIn 8. done at cycle 4, busy low from then on.
- Hold: same table, hold=1 during the cycle after the first issue → the second issue slips one cycle, ru_valid gap is 1 cycle, done at cycle 5.
- Table limits:
  - Write 5 distinct entries with MAX_FAULTS=4 → count=4, table_full=1, fault_err=1.
  - Write row=011 → rejected, fault_err=1.
  - Write a duplicate → count unchanged, fault_err unaffected.
  - fault_clear → count=0, fault_err=0.
- Locked during busy: fault_wr_en, fault_clear and start asserted mid-ISSUE → table unchanged, fault_err=1, pass completes normally.
- Reset mid-pass: rst low while issuing entry 1 of 3 → outputs 0 asynchronously, count=0. No done pulse, then IDLE.

Source files
------------

// File: rtl/recompute_scheduler.sv
// Fault-table sequencer that time-shares the single recompute unit among faulty PEs.
// Issues one table entry per cycle with the PE's weight and row left input, then drains.
module recompute_scheduler #(
    parameter int ROWS       = 3,
    parameter int COLS       = 3,
    parameter int WORD_SIZE  = 16,
    parameter int MAX_FAULTS = 4,
    parameter int RU_LATENCY = 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            fault_wr_en,
    input  logic [ROWS-1:0]                 fault_row_in,
    input  logic [COLS-1:0]                 fault_col_in,
    input  logic                            fault_clear,
    input  logic                            start,
    input  logic                            hold,
    input  logic [ROWS*COLS*WORD_SIZE-1:0]  weights_in,
    input  logic [ROWS*WORD_SIZE-1:0]       left_in,
    output logic [ROWS-1:0]                 faultyRowOut,
    output logic [COLS-1:0]                 faultyColOut,
    output logic [WORD_SIZE-1:0]            Weight,
    output logic [WORD_SIZE-1:0]            LeftIn,
    output logic                            ru_valid,
    output logic                            busy,
    output logic                            done,
    output logic [$clog2(MAX_FAULTS+1)-1:0] fault_count,
    output logic                            table_full,
    output logic                            fault_err
);

    localparam int CW = $clog2(MAX_FAULTS + 1);
    localparam int IW = (MAX_FAULTS > 1) ? $clog2(MAX_FAULTS) : 1;
    localparam int DW = $clog2(RU_LATENCY + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                 state_r, state_s;
    logic [IW-1:0]          idx_r, idx_s;
    logic [DW-1:0]          drain_r, drain_s;
    logic [ROWS-1:0]        tab_row_r [MAX_FAULTS];
    logic [ROWS-1:0]        tab_row_s [MAX_FAULTS];
    logic [COLS-1:0]        tab_col_r [MAX_FAULTS];
    logic [COLS-1:0]        tab_col_s [MAX_FAULTS];
    logic [CW-1:0]          count_r, count_s;
    logic                   err_r, err_s;
    logic                   dup_s;
    logic [ROWS-1:0]        row_out_r, row_out_s, sel_row_s;
    logic [COLS-1:0]        col_out_r, col_out_s, sel_col_s;
    logic [WORD_SIZE-1:0]   weight_r, weight_s, sel_weight_s;
    logic [WORD_SIZE-1:0]   left_r, left_s, sel_left_s;
    logic                   ru_valid_r, ru_valid_s;
    logic                   busy_r, done_r, full_r;

    function automatic logic row_onehot(input logic [ROWS-1:0] v);
        return (v != '0) && ((v & (v - ROWS'(1))) == '0);
    endfunction

    function automatic logic col_onehot(input logic [COLS-1:0] v);
        return (v != '0) && ((v & (v - COLS'(1))) == '0);
    endfunction

    assign faultyRowOut = row_out_r;
    assign faultyColOut = col_out_r;
    assign Weight       = weight_r;
    assign LeftIn       = left_r;
    assign ru_valid     = ru_valid_r;
    assign busy         = busy_r;
    assign done         = done_r;
    assign fault_count  = count_r;
    assign table_full   = full_r;
    assign fault_err    = err_r;

    // Duplicate detection against the currently valid table entries
    always_comb begin
        dup_s = 1'b0;
        for (int i = 0; i < MAX_FAULTS; i++) begin
            dup_s = dup_s | ((CW'(i) < count_r) && (tab_row_r[i] == fault_row_in)
                             && (tab_col_r[i] == fault_col_in));
        end
    end

    // Fault table write / clear / error tracking; the table is locked outside IDLE
    always_comb begin
        tab_row_s = tab_row_r;
        tab_col_s = tab_col_r;
        count_s   = count_r;
        err_s     = err_r;
        if (state_r == IDLE) begin
            if (fault_clear) begin
                count_s = '0;
                err_s   = 1'b0;
            end else if (fault_wr_en) begin
                if (!row_onehot(fault_row_in) || !col_onehot(fault_col_in)) begin
                    err_s = 1'b1;
                end else if (dup_s) begin
                    err_s = err_r;
                end else if (count_r == CW'(MAX_FAULTS)) begin
                    err_s = 1'b1;
                end else begin
                    for (int i = 0; i < MAX_FAULTS; i++) begin
                        tab_row_s[i] = (CW'(i) == count_r) ? fault_row_in : tab_row_r[i];
                        tab_col_s[i] = (CW'(i) == count_r) ? fault_col_in : tab_col_r[i];
                    end
                    count_s = count_r + CW'(1);
                end
            end else begin
                count_s = count_r;
            end
        end else if (fault_wr_en) begin
            err_s = 1'b1;
        end else begin
            err_s = err_r;
        end
    end

    // Select weight and left input for the one-hot (row, col) at idx
    always_comb begin
        sel_row_s    = tab_row_r[idx_r];
        sel_col_s    = tab_col_r[idx_r];
        sel_weight_s = '0;
        sel_left_s   = '0;
        for (int r = 0; r < ROWS; r++) begin
            sel_left_s = sel_left_s | ({WORD_SIZE{sel_row_s[r]}} & left_in[r*WORD_SIZE +: WORD_SIZE]);
            for (int c = 0; c < COLS; c++) begin
                sel_weight_s = sel_weight_s | ({WORD_SIZE{sel_row_s[r] & sel_col_s[c]}}
                               & weights_in[(r*COLS+c)*WORD_SIZE +: WORD_SIZE]);
            end
        end
    end

    // Pass sequencing: next state and next issue-output values
    always_comb begin
        state_s    = state_r;
        idx_s      = idx_r;
        drain_s    = drain_r;
        row_out_s  = row_out_r;
        col_out_s  = col_out_r;
        weight_s   = weight_r;
        left_s     = left_r;
        ru_valid_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    idx_s = '0;
                    // An empty table still spends one busy cycle so done lands one edge after start
                    if (count_r == '0) begin
                        state_s = DRAIN;
                        drain_s = '0;
                    end else begin
                        state_s = ISSUE;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            ISSUE: begin
                if (!hold) begin
                    row_out_s  = sel_row_s;
                    col_out_s  = sel_col_s;
                    weight_s   = sel_weight_s;
                    left_s     = sel_left_s;
                    ru_valid_s = 1'b1;
                    if ((CW'(idx_r) + CW'(1)) == count_r) begin
                        state_s = DRAIN;
                        drain_s = DW'(RU_LATENCY);
                    end else begin
                        idx_s = idx_r + IW'(1);
                    end
                end else begin
                    ru_valid_s = 1'b0;
                end
            end
            DRAIN: begin
                if (drain_r == '0) begin
                    state_s = DONE;
                end else begin
                    drain_s = drain_r - DW'(1);
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, table and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= IDLE;
            idx_r      <= '0;
            drain_r    <= '0;
            for (int i = 0; i < MAX_FAULTS; i++) begin
                tab_row_r[i] <= '0;
                tab_col_r[i] <= '0;
            end
            count_r    <= '0;
            err_r      <= 1'b0;
            row_out_r  <= '0;
            col_out_r  <= '0;
            weight_r   <= '0;
            left_r     <= '0;
            ru_valid_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            full_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            idx_r      <= idx_s;
            drain_r    <= drain_s;
            tab_row_r  <= tab_row_s;
            tab_col_r  <= tab_col_s;
            count_r    <= count_s;
            err_r      <= err_s;
            row_out_r  <= row_out_s;
            col_out_r  <= col_out_s;
            weight_r   <= weight_s;
            left_r     <= left_s;
            ru_valid_r <= ru_valid_s;
            busy_r     <= (state_s == ISSUE) || (state_s == DRAIN);
            done_r     <= (state_s == DONE);
            full_r     <= (count_s == CW'(MAX_FAULTS));
        end
    end

endmodule

// File: tb/tb_recompute_scheduler.sv
// Directed self-checking bench for recompute_scheduler (3x3 array, 16-bit words, 4 faults, latency 1).
module tb_recompute_scheduler;

    logic         clk = 1'b0;
    logic         rst;
    logic         fault_wr_en, fault_clear, start, hold;
    logic [2:0]   fault_row_in, fault_col_in;
    logic [143:0] weights_in;
    logic [47:0]  left_in;
    logic [2:0]   faultyRowOut, faultyColOut;
    logic [15:0]  Weight, LeftIn;
    logic         ru_valid, busy, done, table_full, fault_err;
    logic [2:0]   fault_count;

    int checks = 0;
    int failures = 0;

    recompute_scheduler #(
        .ROWS(3), .COLS(3), .WORD_SIZE(16), .MAX_FAULTS(4), .RU_LATENCY(1)
    ) dut (
        .clk(clk), .rst(rst), .fault_wr_en(fault_wr_en), .fault_row_in(fault_row_in),
        .fault_col_in(fault_col_in), .fault_clear(fault_clear), .start(start), .hold(hold),
        .weights_in(weights_in), .left_in(left_in), .faultyRowOut(faultyRowOut),
        .faultyColOut(faultyColOut), .Weight(Weight), .LeftIn(LeftIn), .ru_valid(ru_valid),
        .busy(busy), .done(done), .fault_count(fault_count), .table_full(table_full),
        .fault_err(fault_err)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic write_fault(input logic [2:0] r, input logic [2:0] c);
        fault_wr_en = 1'b1; fault_row_in = r; fault_col_in = c;
        tick();
        fault_wr_en = 1'b0; fault_row_in = 3'b000; fault_col_in = 3'b000;
    endtask

    task automatic clear_table;
        fault_clear = 1'b1;
        tick();
        fault_clear = 1'b0;
    endtask

    task automatic test_reset;
        logic [50:0] outs;
        rst = 1'b0;
        repeat (2) tick();
        outs = {faultyRowOut, faultyColOut, Weight, LeftIn, ru_valid, busy, done, fault_count, table_full, fault_err};
        checks++;
        if (outs !== 51'd0) begin failures++; $display("FAIL reset_outputs got=%h exp=0", outs); end
        rst = 1'b1;
        tick();
        outs = {faultyRowOut, faultyColOut, Weight, LeftIn, ru_valid, busy, done, fault_count, table_full, fault_err};
        checks++;
        if (outs !== 51'd0) begin failures++; $display("FAIL idle_after_reset got=%h exp=0", outs); end
    endtask

    task automatic test_empty_pass;
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if ({busy, done, ru_valid} !== 3'b100) begin failures++; $display("FAIL empty_t0 busy/done/vld got=%b exp=100", {busy, done, ru_valid}); end
        tick();
        checks++;
        if ({busy, done, ru_valid} !== 3'b010) begin failures++; $display("FAIL empty_done busy/done/vld got=%b exp=010", {busy, done, ru_valid}); end
        tick();
        checks++;
        if ({busy, done, ru_valid} !== 3'b000) begin failures++; $display("FAIL empty_after busy/done/vld got=%b exp=000", {busy, done, ru_valid}); end
    endtask

    task automatic test_two_fault;
        write_fault(3'b001, 3'b010);
        write_fault(3'b100, 3'b001);
        checks++;
        if (fault_count !== 3'd2) begin failures++; $display("FAIL two_count got=%0d exp=2", fault_count); end
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if ({busy, ru_valid} !== 2'b10) begin failures++; $display("FAIL two_t0 busy/vld got=%b exp=10", {busy, ru_valid}); end
        tick();
        checks++;
        if ({ru_valid, faultyRowOut, faultyColOut, Weight, LeftIn} !== {1'b1, 3'b001, 3'b010, 16'd3, 16'd4}) begin
            failures++; $display("FAIL two_issue0 got vld=%b r=%b c=%b w=%0d l=%0d exp vld=1 r=001 c=010 w=3 l=4", ru_valid, faultyRowOut, faultyColOut, Weight, LeftIn);
        end
        tick();
        checks++;
        if ({ru_valid, faultyRowOut, faultyColOut, Weight, LeftIn} !== {1'b1, 3'b100, 3'b001, 16'd7, 16'd8}) begin
            failures++; $display("FAIL two_issue1 got vld=%b r=%b c=%b w=%0d l=%0d exp vld=1 r=100 c=001 w=7 l=8", ru_valid, faultyRowOut, faultyColOut, Weight, LeftIn);
        end
        tick();
        checks++;
        if ({ru_valid, busy, done, Weight} !== {3'b010, 16'd7}) begin failures++; $display("FAIL two_drain vld/busy/done=%b w=%0d exp 010 w=7", {ru_valid, busy, done}, Weight); end
        tick();
        checks++;
        if ({busy, done} !== 2'b01) begin failures++; $display("FAIL two_done busy/done got=%b exp=01", {busy, done}); end
        tick();
        checks++;
        if ({busy, done} !== 2'b00) begin failures++; $display("FAIL two_idle busy/done got=%b exp=00", {busy, done}); end
    endtask

    task automatic test_hold;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        checks++;
        if ({ru_valid, Weight} !== {1'b1, 16'd3}) begin failures++; $display("FAIL hold_issue0 vld=%b w=%0d exp vld=1 w=3", ru_valid, Weight); end
        hold = 1'b1;
        tick();
        hold = 1'b0;
        checks++;
        if ({ru_valid, faultyRowOut, Weight} !== {1'b0, 3'b001, 16'd3}) begin failures++; $display("FAIL hold_gap vld=%b r=%b w=%0d exp vld=0 r=001 w=3", ru_valid, faultyRowOut, Weight); end
        tick();
        checks++;
        if ({ru_valid, faultyRowOut, Weight, LeftIn} !== {1'b1, 3'b100, 16'd7, 16'd8}) begin failures++; $display("FAIL hold_issue1 vld=%b r=%b w=%0d l=%0d exp vld=1 r=100 w=7 l=8", ru_valid, faultyRowOut, Weight, LeftIn); end
        tick();
        checks++;
        if ({ru_valid, done} !== 2'b00) begin failures++; $display("FAIL hold_drain vld/done got=%b exp=00", {ru_valid, done}); end
        tick();
        checks++;
        if ({busy, done} !== 2'b01) begin failures++; $display("FAIL hold_done busy/done got=%b exp=01", {busy, done}); end
        tick();
    endtask

    task automatic test_back_to_back;
        start = 1'b1;
        repeat (5) tick();
        checks++;
        if (done !== 1'b1) begin failures++; $display("FAIL b2b_done got=%b exp=1", done); end
        tick();
        checks++;
        if ({busy, done} !== 2'b00) begin failures++; $display("FAIL b2b_ignored busy/done got=%b exp=00", {busy, done}); end
        tick();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL b2b_restart busy got=%b exp=1", busy); end
        repeat (5) tick();
        checks++;
        if ({busy, done} !== 2'b00) begin failures++; $display("FAIL b2b_end busy/done got=%b exp=00", {busy, done}); end
    endtask

    task automatic test_table_limits;
        clear_table();
        write_fault(3'b001, 3'b001);
        write_fault(3'b001, 3'b010);
        write_fault(3'b001, 3'b100);
        write_fault(3'b010, 3'b001);
        checks++;
        if ({fault_count, table_full, fault_err} !== {3'd4, 2'b10}) begin failures++; $display("FAIL full_at4 cnt=%0d full=%b err=%b exp 4 1 0", fault_count, table_full, fault_err); end
        write_fault(3'b010, 3'b010);
        checks++;
        if ({fault_count, table_full, fault_err} !== {3'd4, 2'b11}) begin failures++; $display("FAIL overflow cnt=%0d full=%b err=%b exp 4 1 1", fault_count, table_full, fault_err); end
        clear_table();
        checks++;
        if ({fault_count, table_full, fault_err} !== {3'd0, 2'b00}) begin failures++; $display("FAIL clear cnt=%0d full=%b err=%b exp 0 0 0", fault_count, table_full, fault_err); end
        write_fault(3'b011, 3'b001);
        checks++;
        if ({fault_count, fault_err} !== {3'd0, 1'b1}) begin failures++; $display("FAIL not_onehot cnt=%0d err=%b exp 0 1", fault_count, fault_err); end
        clear_table();
        write_fault(3'b001, 3'b001);
        write_fault(3'b001, 3'b001);
        checks++;
        if ({fault_count, fault_err} !== {3'd1, 1'b0}) begin failures++; $display("FAIL duplicate cnt=%0d err=%b exp 1 0", fault_count, fault_err); end
        fault_clear = 1'b1;
        fault_wr_en = 1'b1; fault_row_in = 3'b010; fault_col_in = 3'b010;
        tick();
        fault_clear = 1'b0; fault_wr_en = 1'b0;
        checks++;
        if (fault_count !== 3'd0) begin failures++; $display("FAIL clear_beats_write cnt=%0d exp 0", fault_count); end
    endtask

    task automatic test_locked_busy;
        write_fault(3'b001, 3'b001);
        write_fault(3'b010, 3'b010);
        write_fault(3'b100, 3'b100);
        start = 1'b1;
        tick();
        fault_wr_en = 1'b1; fault_row_in = 3'b100; fault_col_in = 3'b001; fault_clear = 1'b1;
        tick();
        fault_wr_en = 1'b0; fault_clear = 1'b0; start = 1'b0;
        checks++;
        if ({fault_count, fault_err, ru_valid, Weight} !== {3'd3, 2'b11, 16'h0100}) begin
            failures++; $display("FAIL locked cnt=%0d err=%b vld=%b w=%h exp 3 1 1 0100", fault_count, fault_err, ru_valid, Weight);
        end
        tick();
        tick();
        checks++;
        if ({ru_valid, faultyRowOut, faultyColOut, Weight, LeftIn} !== {1'b1, 3'b100, 3'b100, 16'h0108, 16'd8}) begin
            failures++; $display("FAIL locked_issue2 vld=%b r=%b c=%b w=%h l=%0d exp 1 100 100 0108 8", ru_valid, faultyRowOut, faultyColOut, Weight, LeftIn);
        end
        tick();
        tick();
        checks++;
        if ({busy, done, fault_count} !== {2'b01, 3'd3}) begin failures++; $display("FAIL locked_done busy/done=%b cnt=%0d exp 01 3", {busy, done}, fault_count); end
        tick();
    endtask

    task automatic test_reset_mid_pass;
        logic [50:0] outs;
        logic saw_done;
        clear_table();
        write_fault(3'b001, 3'b001);
        write_fault(3'b010, 3'b010);
        write_fault(3'b100, 3'b100);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        rst = 1'b0;
        #1;
        outs = {faultyRowOut, faultyColOut, Weight, LeftIn, ru_valid, busy, done, fault_count, table_full, fault_err};
        checks++;
        if (outs !== 51'd0) begin failures++; $display("FAIL async_reset got=%h exp=0", outs); end
        tick();
        rst = 1'b1;
        saw_done = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            saw_done = saw_done | done | busy;
        end
        checks++;
        if ({saw_done, fault_count} !== {1'b0, 3'd0}) begin failures++; $display("FAIL post_reset done_or_busy=%b cnt=%0d exp 0 0", saw_done, fault_count); end
    endtask

    initial begin
        rst = 1'b0; fault_wr_en = 1'b0; fault_clear = 1'b0; start = 1'b0; hold = 1'b0;
        fault_row_in = 3'b000; fault_col_in = 3'b000;
        for (int k = 0; k < 9; k++) weights_in[k*16 +: 16] = 16'h0100 + 16'(k);
        weights_in[1*16 +: 16] = 16'd3;
        weights_in[6*16 +: 16] = 16'd7;
        left_in = {16'd8, 16'h0055, 16'd4};
        test_reset();
        test_empty_pass();
        test_two_fault();
        test_hold();
        test_back_to_back();
        test_table_limits();
        test_locked_busy();
        test_reset_mid_pass();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
